// File: rtl/rr_arb8_32bits.sv
// rr_arb8_32bits: 8-way round-robin arbiter feeding one registered 32-bit output
// stage with valid/ready handshake and a one-cycle ack pulse back to the served requester.

module mx8_32bits (
   input  logic [2:0]  sel,
   input  logic [31:0] d0,
   input  logic [31:0] d1,
   input  logic [31:0] d2,
   input  logic [31:0] d3,
   input  logic [31:0] d4,
   input  logic [31:0] d5,
   input  logic [31:0] d6,
   input  logic [31:0] d7,
   output logic [31:0] y
);
   always_comb begin
      y = sel[2] ? (sel[1] ? (sel[0] ? d7 : d6) : (sel[0] ? d5 : d4))
                 : (sel[1] ? (sel[0] ? d3 : d2) : (sel[0] ? d1 : d0));
   end
endmodule

module rr_arb8_32bits (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  req,
   input  logic [31:0] d0,
   input  logic [31:0] d1,
   input  logic [31:0] d2,
   input  logic [31:0] d3,
   input  logic [31:0] d4,
   input  logic [31:0] d5,
   input  logic [31:0] d6,
   input  logic [31:0] d7,
   input  logic        o_ready,
   output logic        o_valid,
   output logic [31:0] o_data,
   output logic [2:0]  o_id,
   output logic        s2,
   output logic        s1,
   output logic        s0,
   output logic [7:0]  ack,
   output logic        busy,
   output logic [15:0] xfer_cnt
);
   typedef enum logic [1:0] {IDLE, SEND, ACK} state_t;

   state_t      state_q, state_d;
   logic [2:0]  ptr_q, ptr_d;
   logic        o_valid_q, o_valid_d;
   logic [31:0] o_data_q, o_data_d;
   logic [2:0]  o_id_q, o_id_d;
   logic [2:0]  sel_q, sel_d;
   logic [7:0]  ack_q, ack_d;
   logic [15:0] xfer_cnt_q, xfer_cnt_d;
   logic [2:0]  grant;
   logic [2:0]  mux_sel;
   logic [31:0] mux_y;

   // Scan from ptr+7 down to ptr so the lowest offset from ptr wins.
   always_comb begin
      grant = ptr_q;
      for (int k = 7; k >= 0; k--) begin
         if (req[3'(ptr_q + 3'(k))]) grant = 3'(ptr_q + 3'(k));
      end
   end

   // In IDLE the mux must already point at the winner so its word is captured on the grant edge.
   assign mux_sel = (state_q == IDLE) ? grant : sel_q;

   mx8_32bits u_mux (
      .sel(mux_sel),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .d4(d4), .d5(d5), .d6(d6), .d7(d7),
      .y(mux_y)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      o_valid_d  = o_valid_q;
      o_data_d   = o_data_q;
      o_id_d     = o_id_q;
      sel_d      = sel_q;
      ack_d      = '0;
      xfer_cnt_d = xfer_cnt_q;
      case (state_q)
         IDLE: begin
            o_valid_d = |req;
            if (|req) begin
               state_d  = SEND;
               o_data_d = mux_y;
               o_id_d   = grant;
               sel_d    = grant;
            end
         end
         SEND: begin
            if (o_valid_q && o_ready) begin
               state_d    = ACK;
               o_valid_d  = 1'b0;
               ack_d      = 8'(1) << o_id_q;
               ptr_d      = o_id_q + 3'd1;
               xfer_cnt_d = xfer_cnt_q + 16'd1;
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         o_valid_q  <= 1'b0;
         o_data_q   <= '0;
         o_id_q     <= '0;
         sel_q      <= '0;
         ack_q      <= '0;
         xfer_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         o_valid_q  <= o_valid_d;
         o_data_q   <= o_data_d;
         o_id_q     <= o_id_d;
         sel_q      <= sel_d;
         ack_q      <= ack_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   assign o_valid  = o_valid_q;
   assign o_data   = o_data_q;
   assign o_id     = o_id_q;
   assign {s2, s1, s0} = sel_q;
   assign ack      = ack_q;
   assign busy     = (state_q != IDLE);
   assign xfer_cnt = xfer_cnt_q;
endmodule

// File: tb/tb_rr_arb8_32bits.sv
// tb_rr_arb8_32bits: directed and randomized checks of the round-robin arbiter
// against a transaction-level model of grant order, handshake and counters.

module tb_rr_arb8_32bits;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  req = '0;
   logic [31:0] d [8];
   logic        o_ready = 1'b0;
   logic        o_valid;
   logic [31:0] o_data;
   logic [2:0]  o_id;
   logic        s2, s1, s0;
   logic [7:0]  ack;
   logic        busy;
   logic [15:0] xfer_cnt;

   int total = 0;
   int bad = 0;
   int mptr = 0;
   logic [15:0] mcnt = '0;

   always #5 clk = ~clk;

   rr_arb8_32bits dut (
      .clk(clk), .reset(reset), .req(req),
      .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
      .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
      .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .o_id(o_id),
      .s2(s2), .s1(s1), .s0(s0), .ack(ack), .busy(busy), .xfer_cnt(xfer_cnt)
   );

   function automatic int pick(input logic [7:0] r, input int p);
      for (int k = 0; k < 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
      return -1;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      req = '0;
      o_ready = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      mptr = 0;
      mcnt = '0;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 8; i++) d[i] = '0;
      #2;
      total++;
      if ({o_valid, o_data, o_id, s2, s1, s0, ack, busy, xfer_cnt} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got v=%b data=%h id=%0d sel=%b ack=%h busy=%b cnt=%h want all zero",
                  o_valid, o_data, o_id, {s2, s1, s0}, ack, busy, xfer_cnt);
      end
      do_reset;
   endtask

   task automatic test_single;
      do_reset;
      d[3] = 32'hDEADBEEF;
      req = 8'h08;
      o_ready = 1'b1;
      step;
      total++;
      if (!(o_valid === 1'b1 && o_data === 32'hDEADBEEF && o_id === 3'd3 && {s2, s1, s0} === 3'b011 && busy === 1'b1)) begin
         bad++;
         $display("FAIL single_grant: got v=%b data=%h id=%0d sel=%b busy=%b want 1 deadbeef 3 011 1",
                  o_valid, o_data, o_id, {s2, s1, s0}, busy);
      end
      step;
      total++;
      if (ack !== 8'h08 || o_valid !== 1'b0 || xfer_cnt !== 16'd1) begin
         bad++;
         $display("FAIL single_ack: got ack=%h v=%b cnt=%0d want 08 0 1", ack, o_valid, xfer_cnt);
      end
      req = '0;
      step;
      total++;
      if (ack !== 8'h00 || busy !== 1'b0) begin
         bad++;
         $display("FAIL single_ack_pulse: got ack=%h busy=%b want 00 0", ack, busy);
      end
      d[0] = 32'h11111111;
      d[5] = 32'h55555555;
      req = 8'h21;
      step;
      total++;
      if (o_id !== 3'd5 || o_data !== 32'h55555555) begin
         bad++;
         $display("FAIL single_ptr4: got id=%0d data=%h want 5 55555555", o_id, o_data);
      end
      step;
      req = 8'h01;
      step;
   endtask

   task automatic test_all;
      do_reset;
      for (int i = 0; i < 8; i++) d[i] = 32'(i + 1);
      req = 8'hFF;
      o_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step;
         total++;
         if (o_valid !== 1'b1 || o_id !== 3'(i) || o_data !== 32'(i + 1)) begin
            bad++;
            $display("FAIL all_grant%0d: got v=%b id=%0d data=%h want 1 %0d %0h", i, o_valid, o_id, o_data, i, i + 1);
         end
         step;
         total++;
         if (ack !== (8'h01 << i)) begin
            bad++;
            $display("FAIL all_ack%0d: got %h want %h", i, ack, 8'h01 << i);
         end
         req[i] = 1'b0;
         step;
      end
      total++;
      if (xfer_cnt !== 16'd8) begin
         bad++;
         $display("FAIL all_count: got %0d want 8", xfer_cnt);
      end
   endtask

   task automatic test_wrap;
      int exp_id [2];
      exp_id[0] = 7;
      exp_id[1] = 0;
      do_reset;
      o_ready = 1'b1;
      d[5] = 32'hA5A5A5A5;
      req = 8'h20;
      step;
      step;
      req = '0;
      step;
      d[7] = 32'h77777777;
      d[0] = 32'h00000070;
      req = 8'h81;
      for (int j = 0; j < 2; j++) begin
         step;
         total++;
         if (o_id !== 3'(exp_id[j]) || o_data !== d[exp_id[j]]) begin
            bad++;
            $display("FAIL wrap_grant%0d: got id=%0d data=%h want %0d %h", j, o_id, o_data, exp_id[j], d[exp_id[j]]);
         end
         step;
         req[exp_id[j]] = 1'b0;
         step;
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] w;
      do_reset;
      w = $urandom;
      d[2] = w;
      req = 8'h04;
      step;
      for (int c = 0; c < 5; c++) begin
         req = 8'h04 | 8'($urandom);
         d[(c + 3) % 8] = $urandom;
         step;
         total++;
         if (o_valid !== 1'b1 || o_data !== w || o_id !== 3'd2 || {s2, s1, s0} !== 3'd2 || ack !== 8'h00) begin
            bad++;
            $display("FAIL bp_hold%0d: got v=%b data=%h id=%0d sel=%b ack=%h want 1 %h 2 010 00",
                     c, o_valid, o_data, o_id, {s2, s1, s0}, ack, w);
         end
      end
      o_ready = 1'b1;
      step;
      total++;
      if (ack !== 8'h04 || o_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_ack: got ack=%h v=%b want 04 0", ack, o_valid);
      end
      req = '0;
      step;
      total++;
      if (ack !== 8'h00) begin
         bad++;
         $display("FAIL bp_single_ack: got %h want 00", ack);
      end
   endtask

   task automatic test_reset_mid;
      do_reset;
      d[4] = 32'h44444444;
      d[1] = 32'h10101010;
      req = 8'h10;
      step;
      step;
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (o_valid !== 1'b0 || ack !== 8'h00 || busy !== 1'b0 || o_data !== '0 || xfer_cnt !== '0) begin
         bad++;
         $display("FAIL mid_reset: got v=%b ack=%h busy=%b data=%h cnt=%h want all zero", o_valid, ack, busy, o_data, xfer_cnt);
      end
      step;
      req = 8'h02;
      reset = 1'b0;
      step;
      total++;
      if (o_valid !== 1'b1 || o_id !== 3'd1 || o_data !== 32'h10101010) begin
         bad++;
         $display("FAIL mid_regrant: got v=%b id=%0d data=%h want 1 1 10101010", o_valid, o_id, o_data);
      end
   endtask

   task automatic test_cnt_wrap;
      do_reset;
      force dut.xfer_cnt_q = 16'hFFFF;
      #1;
      release dut.xfer_cnt_q;
      total++;
      if (xfer_cnt !== 16'hFFFF) begin
         bad++;
         $display("FAIL cnt_preload: got %h want ffff", xfer_cnt);
      end
      o_ready = 1'b1;
      req = 8'h01;
      step;
      step;
      req = '0;
      total++;
      if (xfer_cnt !== 16'h0000) begin
         bad++;
         $display("FAIL cnt_wrap: got %h want 0000", xfer_cnt);
      end
      step;
   endtask

   task automatic test_random;
      int ph;
      int cur_id;
      int g;
      logic [31:0] cur_data;
      logic [7:0] rq;
      logic rdy;
      do_reset;
      ph = 0;
      cur_id = 0;
      cur_data = '0;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 8; i++) begin
            if (!req[i] && $urandom_range(3) == 0) begin
               d[i] = $urandom;
               req[i] = 1'b1;
            end
         end
         o_ready = ($urandom_range(2) != 0);
         rq = req;
         rdy = o_ready;
         step;
         total++;
         if (ph == 0) begin
            if (rq != 0) begin
               g = pick(rq, mptr);
               if (o_valid !== 1'b1 || o_id !== 3'(g) || o_data !== d[g] || {s2, s1, s0} !== 3'(g) || ack !== 8'h00) begin
                  bad++;
                  $display("FAIL rnd_grant c=%0d: got v=%b id=%0d data=%h ack=%h want 1 %0d %h 00", c, o_valid, o_id, o_data, ack, g, d[g]);
               end
               cur_id = g;
               cur_data = d[g];
               ph = 1;
            end else if (o_valid !== 1'b0 || ack !== 8'h00 || busy !== 1'b0) begin
               bad++;
               $display("FAIL rnd_idle c=%0d: got v=%b ack=%h busy=%b want 0 00 0", c, o_valid, ack, busy);
            end
         end else if (ph == 1) begin
            if (rdy) begin
               mcnt = mcnt + 16'd1;
               mptr = (cur_id + 1) % 8;
               if (o_valid !== 1'b0 || ack !== (8'h01 << cur_id) || xfer_cnt !== mcnt || busy !== 1'b1) begin
                  bad++;
                  $display("FAIL rnd_ack c=%0d: got v=%b ack=%h cnt=%0d want 0 %h %0d", c, o_valid, ack, xfer_cnt, 8'h01 << cur_id, mcnt);
               end
               req[cur_id] = 1'b0;
               ph = 2;
            end else if (o_valid !== 1'b1 || o_id !== 3'(cur_id) || o_data !== cur_data || ack !== 8'h00) begin
               bad++;
               $display("FAIL rnd_hold c=%0d: got v=%b id=%0d data=%h ack=%h want 1 %0d %h 00", c, o_valid, o_id, o_data, ack, cur_id, cur_data);
            end
         end else begin
            if (o_valid !== 1'b0 || ack !== 8'h00 || busy !== 1'b0) begin
               bad++;
               $display("FAIL rnd_ackend c=%0d: got v=%b ack=%h busy=%b want 0 00 0", c, o_valid, ack, busy);
            end
            ph = 0;
         end
      end
      total++;
      if (mcnt < 16'd50) begin
         bad++;
         $display("FAIL rnd_progress: got %0d transfers want at least 50", mcnt);
      end
   endtask

   initial begin
      test_reset;
      test_single;
      test_all;
      test_wrap;
      test_backpressure;
      test_reset_mid;
      test_cnt_wrap;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
